store_checkout: RTL

STORE_CHECKOUT -- requirements
Module: store_checkout

---
 rtl/store_checkout.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/store_checkout.sv
// Checkout register: prices scanned items into a saturating binary total,
// then converts the total to BCD by shift-add-3, one bit per clock.
module store_checkout #(
  parameter int DIGITS    = 4,
  parameter int TOTAL_W   = 14,
  parameter int MAX_ITEMS = 15,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            item,
  input  logic                  scan,
  input  logic                  checkout,
  input  logic                  clear,
  output logic [TOTAL_W-1:0]    total,
  output logic [CNT_W-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  localparam int BW    = $clog2(TOTAL_W + 1);
  localparam int SUM_W = TOTAL_W + 10;
  localparam logic [TOTAL_W-1:0] MAX_TOTAL = TOTAL_W'(10**DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW
  } state_t;

  state_t               state_q, state_n;
  logic [TOTAL_W-1:0]   total_q, total_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic                 ovf_q, ovf_n;
  logic                 err_q, err_n;
  logic                 done_q, done_n;
  logic [TOTAL_W-1:0]   bin_q, bin_n;
  logic [4*DIGITS-1:0]  acc_q, acc_n;
  logic [4*DIGITS-1:0]  bcd_q, bcd_n;
  logic [BW-1:0]        bitcnt_q, bitcnt_n;

  logic [9:0]           base, price;
  logic                 valid;
  logic [SUM_W-1:0]     sum;
  logic                 sat;
  logic [4*DIGITS-1:0]  adj, shifted;

  // Discounted codes are exactly those with item[1] set.
  always_comb begin
    valid = 1'b1;
    base  = '0;
    case (item)
      3'b000:  base = 10'd250;
      3'b001:  base = 10'd120;
      3'b011:  base = 10'd80;
      3'b100:  base = 10'd15;
      3'b101:  base = 10'd900;
      3'b110:  base = 10'd40;
      default: valid = 1'b0;
    endcase
    price = item[1] ? (base >> 1) : base;
  end

  always_comb begin
    sum = SUM_W'(total_q) + SUM_W'(price);
    sat = (sum > SUM_W'(MAX_TOTAL));
  end

  // One double-dabble step: adjust every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    adj = acc_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    shifted = {adj[4*DIGITS-2:0], bin_q[TOTAL_W-1]};
  end

  always_comb begin
    state_n  = state_q;
    total_n  = total_q;
    count_n  = count_q;
    ovf_n    = ovf_q;
    err_n    = 1'b0;
    done_n   = 1'b0;
    bin_n    = bin_q;
    acc_n    = acc_q;
    bitcnt_n = bitcnt_q;
    bcd_n    = bcd_q;
    case (state_q)
      IDLE: begin
        bcd_n = '0;
        if (clear) begin
          total_n = '0;
          count_n = '0;
          ovf_n   = 1'b0;
        end else if (checkout) begin
          state_n  = CONVERT;
          bin_n    = total_q;
          acc_n    = '0;
          bitcnt_n = '0;
        end else if (scan) begin
          if (valid && (count_q < CNT_W'(MAX_ITEMS))) begin
            count_n = count_q + 1'b1;
            if (sat) begin
              total_n = MAX_TOTAL;
              ovf_n   = 1'b1;
            end else begin
              total_n = sum[TOTAL_W-1:0];
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      CONVERT: begin
        if (clear) begin
          state_n  = IDLE;
          total_n  = '0;
          count_n  = '0;
          ovf_n    = 1'b0;
          bin_n    = '0;
          acc_n    = '0;
          bitcnt_n = '0;
          bcd_n    = '0;
        end else begin
          acc_n    = shifted;
          bin_n    = bin_q << 1;
          bitcnt_n = bitcnt_q + 1'b1;
          if (bitcnt_q == BW'(TOTAL_W - 1)) begin
            state_n = SHOW;
            done_n  = 1'b1;
            bcd_n   = shifted;
          end
        end
      end
      SHOW: begin
        if (clear) begin
          state_n = IDLE;
          total_n = '0;
          count_n = '0;
          ovf_n   = 1'b0;
          bcd_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        bcd_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      total_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      bin_q    <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_n;
      total_q  <= total_n;
      count_q  <= count_n;
      ovf_q    <= ovf_n;
      err_q    <= err_n;
      done_q   <= done_n;
      bin_q    <= bin_n;
      acc_q    <= acc_n;
      bcd_q    <= bcd_n;
      bitcnt_q <= bitcnt_n;
    end
  end

  assign total = total_q;
  assign count = count_q;
  assign bcd   = bcd_q;
  assign busy  = (state_q == CONVERT);
  assign done  = done_q;
  assign err   = err_q;
  assign ovf   = ovf_q;

endmodule
